// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree feature stager.
// Contents: default geometry (feature count, feature width, class width),
// the stager state encoding, and the helper that gives each feature's
// bit offset within the packed feature vector.
package dtree_pkg;

    localparam int N_FEAT_DEF  = 6;
    localparam int FEAT_W_DEF  = 8;
    localparam int CLASS_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } stager_state_t;

    // Feature k occupies bits [feat_off(k, w) +: w] of the packed vector.
    function automatic int feat_off(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/dtree_idle_timer.sv
// Loadable down-counter with a terminal flag.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (count clears to 0)
//   load, load_val  load the counter (load wins over dec)
//   dec             decrement by one; the count saturates at 0
//   done            high while the count is 0
module dtree_idle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (dec && count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/dtree_feature_stager.sv
// Sequential front-end for the combinational decision tree. It collects one
// feature byte per handshake into feat_vec, holds the vector for SETTLE
// cycles, captures the tree's class and offers it downstream on a
// valid/ready handshake.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_last   feature byte stream
//   feat_vec                       registered vector driving the tree
//   cls_in                         class returned by the tree
//   out_valid/out_ready/out_class/out_err  result handshake
//   busy                           high unless idle at the start of a frame
// Optional feature: define DTREE_STAGER_TIMEOUT_EN to abandon a partial
// frame after TIMEOUT idle cycles (reported as an error result).
module dtree_feature_stager
    import dtree_pkg::*;
#(
    parameter int N_FEAT  = N_FEAT_DEF,
    parameter int FEAT_W  = FEAT_W_DEF,
    parameter int CLASS_W = CLASS_W_DEF,
    parameter int SETTLE  = 1,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FEAT_W-1:0]        in_data,
    input  logic                     in_last,
    output logic [N_FEAT*FEAT_W-1:0] feat_vec,
    input  logic [CLASS_W-1:0]       cls_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
    output logic                     out_err,
    output logic                     busy
);

    localparam int                IDX_W    = $clog2(N_FEAT);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FEAT - 1);

    if (SETTLE < 1 || SETTLE > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("dtree_feature_stager: SETTLE must be 1..15, TIMEOUT 1..255");
    end

    stager_state_t    state;
    logic [IDX_W-1:0] idx;
    logic             err_flag;

    logic accept, at_last, settle_load, settle_done, timeout;
    logic [3:0] settle_val;

    assign in_ready  = rst_n && (state == ST_FILL);
    assign out_valid = (state == ST_HOLD);
    assign busy      = !((state == ST_FILL) && (idx == '0));

    assign accept  = in_valid && in_ready;
    assign at_last = (idx == LAST_IDX);

    // Early-terminated frames also pass through one SETTLE cycle (count 0),
    // so their result appears one edge after the terminating byte.
    assign settle_load = accept && (at_last || in_last);
    assign settle_val  = at_last ? 4'(SETTLE - 1) : 4'd0;

    dtree_idle_timer #(.W(4)) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (settle_load),
        .load_val (settle_val),
        .dec      (state == ST_SETTLE),
        .done     (settle_done)
    );

`ifdef DTREE_STAGER_TIMEOUT_EN
    logic idle, idle_done;

    // Only a partial frame (idx>0) can time out; every accepted byte reloads.
    assign idle    = (state == ST_FILL) && (idx != '0) && !accept;
    assign timeout = idle && idle_done;

    dtree_idle_timer #(.W(8)) u_idle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept),
        .load_val (8'(TIMEOUT)),
        .dec      (idle),
        .done     (idle_done)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_FILL;
            idx       <= '0;
            err_flag  <= 1'b0;
            feat_vec  <= '0;
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    if (accept) begin
                        feat_vec[feat_off(int'(idx), FEAT_W) +: FEAT_W] <= in_data;
                        if (at_last) begin
                            state    <= ST_SETTLE;
                            err_flag <= !in_last;
                        end else if (in_last) begin
                            state    <= ST_SETTLE;
                            err_flag <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else if (timeout) begin
                        state     <= ST_HOLD;
                        out_class <= '0;
                        out_err   <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_done) begin
                        state     <= ST_HOLD;
                        out_err   <= err_flag;
                        out_class <= err_flag ? '0 : cls_in;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state    <= ST_FILL;
                        idx      <= '0;
                        err_flag <= 1'b0;
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_dtree_feature_stager.sv
module tb_dtree_feature_stager;

    logic        clk = 1'b0;
    logic        rst_n, rst4_n;
    logic        in_valid, in_valid4, in_last, out_ready;
    logic [7:0]  in_data;

    logic        in_ready, out_valid, out_err, busy;
    logic [47:0] feat_vec;
    logic [1:0]  cls_in, out_class;

    logic        in_ready4, out_valid4, out_err4, busy4;
    logic [47:0] feat_vec4;
    logic [1:0]  cls_in4, out_class4;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic seen;

    always #5 clk = ~clk;

    // Tree stub: class depends on X5 so a premature sample would show.
    assign cls_in  = feat_vec[41:40]  ^ 2'b10;
    assign cls_in4 = feat_vec4[41:40] ^ 2'b10;

    dtree_feature_stager #(.SETTLE(1), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .feat_vec(feat_vec), .cls_in(cls_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_err(out_err), .busy(busy)
    );

    dtree_feature_stager #(.SETTLE(4), .TIMEOUT(8)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_data(in_data), .in_last(in_last), .feat_vec(feat_vec4), .cls_in(cls_in4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_class(out_class4),
        .out_err(out_err4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic last);
        in_valid  = !sel;
        in_valid4 = sel;
        in_data   = d;
        in_last   = last;
        tick();
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
        in_last   = 1'b0;
    endtask

    task automatic send6(input bit sel, input logic [47:0] v, input logic last);
        for (int k = 0; k < 6; k++)
            send(sel, v[k*8 +: 8], last && (k == 5));
    endtask

    initial begin
        rst_n = 1'b0; rst4_n = 1'b0;
        in_valid = 1'b0; in_valid4 = 1'b0; in_last = 1'b0; in_data = '0;
        out_ready = 1'b1;
        tick(); tick();

        // Reset state
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_feat_vec",  feat_vec,  0);
        chk("rst_busy",      busy,      0);
        chk("rst_class_err", {out_class, out_err}, 0);
        rst_n = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Normal frame
        send6(0, 48'h605040302010, 1'b1);
        chk("norm_vec",      feat_vec,  48'h605040302010);
        chk("norm_valid0",   out_valid, 0);
        chk("norm_ready0",   in_ready,  0);
        chk("norm_busy",     busy,      1);
        tick();
        chk("norm_valid1",   out_valid, 1);
        chk("norm_class",    out_class, 2);
        chk("norm_err",      out_err,   0);
        tick();
        chk("norm_done_vld", out_valid, 0);
        chk("norm_done_rdy", in_ready,  1);

        // Backpressure; stray in_valid during HOLD must be ignored
        out_ready = 1'b0;
        send6(0, 48'h615141312111, 1'b1);
        tick();
        chk("bp_valid", out_valid, 1);
        chk("bp_class", out_class, 3);
        in_valid = 1'b1; in_data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_hold", {out_valid, out_class, out_err, in_ready}, {1'b1, 2'd3, 1'b0, 1'b0});
            chk("bp_vec",  feat_vec, 48'h615141312111);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_rel_vld", out_valid, 0);
        chk("bp_rel_rdy", in_ready,  1);

        // Early last on byte 3
        send(0, 8'hA0, 1'b0);
        send(0, 8'hA1, 1'b0);
        send(0, 8'hA2, 1'b1);
        chk("early_vec",    feat_vec,  48'h615141A2A1A0);
        chk("early_valid0", out_valid, 0);
        tick();
        chk("early_result", {out_valid, out_class, out_err}, {1'b1, 2'd0, 1'b1});
        tick();
        chk("early_idle", {out_valid, in_ready, busy}, {1'b0, 1'b1, 1'b0});
        send6(0, 48'h070504030201, 1'b1);
        chk("refill_vec", feat_vec, 48'h070504030201);
        tick();
        chk("refill_result", {out_valid, out_class, out_err}, {1'b1, 2'd1, 1'b0});
        tick();

        // Missing last
        send6(0, 48'h272524232221, 1'b0);
        chk("miss_valid0", out_valid, 0);
        tick();
        chk("miss_result", {out_valid, out_class, out_err}, {1'b1, 2'd0, 1'b1});
        tick();
        chk("miss_done", out_valid, 0);

        // Partial frame left idle
        send(0, 8'h33, 1'b0);
        send(0, 8'h44, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("tmo_early", seen, 0);
`ifdef DTREE_STAGER_TIMEOUT_EN
        tick();
        chk("tmo_result", {out_valid, out_class, out_err}, {1'b1, 2'd0, 1'b1});
        tick();
`else
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("tmo_never", seen, 0);
        chk("tmo_busy",  busy, 1);
`endif

        // Reset during SETTLE on the SETTLE=4 instance
        rst4_n = 1'b1;
        tick();
        send6(1, 48'h605040302010, 1'b1);
        chk("s4_vec",    feat_vec4,  48'h605040302010);
        chk("s4_valid0", out_valid4, 0);
        tick();
        rst4_n = 1'b0;
        tick();
        chk("s4_rst_out", {feat_vec4, out_valid4, out_class4, out_err4, busy4, in_ready4}, 0);
        rst4_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid4) seen = 1'b1;
        end
        chk("s4_no_pulse", seen, 0);
        chk("s4_idle", {in_ready4, busy4}, {1'b1, 1'b0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
